// File: rtl/pam_op_stack.sv
// Parametrised operand stack for the pamPy stack-machine datapath.
// One op per cycle with guarded overflow/underflow, sticky error flags and a high-water mark.
module pam_op_stack #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  OP_VALID,
    input  logic [2:0]            OP,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic [DATA_WIDTH-1:0] TOS_OUT,
    output logic [DATA_WIDTH-1:0] NOS_OUT,
    output logic [CNT_WIDTH-1:0]  COUNT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  OP_DONE,
    output logic                  ERR_OVERFLOW,
    output logic                  ERR_UNDERFLOW,
    output logic [CNT_WIDTH-1:0]  HIGH_WATER
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO     = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_BINOP   = 3'd4,
        OP_DUP     = 3'd5,
        OP_SWAP    = 3'd6,
        OP_CLEAR   = 3'd7
    } op_e;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_highWater;
    logic                  r_opDone;
    logic                  r_errOv;
    logic                  r_errUn;

    logic                  w_hasOne;
    logic                  w_hasTwo;
    logic                  w_full;
    logic [AW-1:0]         w_tosIdx;
    logic [AW-1:0]         w_nosIdx;
    logic [AW-1:0]         w_topIdx;
    logic [DATA_WIDTH-1:0] w_tos;
    logic [DATA_WIDTH-1:0] w_nos;
    op_e                   w_op;
    logic                  w_accept;
    logic                  w_setOv;
    logic                  w_setUn;
    logic                  w_clear;
    logic [CNT_WIDTH-1:0]  w_nextCount;
    logic                  w_wrA;
    logic [AW-1:0]         w_wrAIdx;
    logic [DATA_WIDTH-1:0] w_wrAData;
    logic                  w_wrB;
    logic [AW-1:0]         w_wrBIdx;
    logic [DATA_WIDTH-1:0] w_wrBData;

    assign w_hasOne = (r_count != '0);
    assign w_hasTwo = (r_count >= TWO);
    assign w_full   = (r_count == DEPTH_C);
    // Index arithmetic wraps in AW bits; the legality guards keep wrapped indices from being used.
    assign w_tosIdx = AW'(r_count - ONE);
    assign w_nosIdx = AW'(r_count - TWO);
    assign w_topIdx = AW'(r_count);
    assign w_tos    = r_mem[w_tosIdx];
    assign w_nos    = r_mem[w_nosIdx];

    always_comb begin
        w_op        = op_e'(OP);
        w_accept    = 1'b0;
        w_setOv     = 1'b0;
        w_setUn     = 1'b0;
        w_clear     = 1'b0;
        w_nextCount = r_count;
        w_wrA       = 1'b0;
        w_wrAIdx    = w_topIdx;
        w_wrAData   = DIN;
        w_wrB       = 1'b0;
        w_wrBIdx    = w_nosIdx;
        w_wrBData   = w_tos;
        if (OP_VALID) begin
            case (w_op)
                OP_PUSH: begin
                    if (w_full) begin
                        w_setOv = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_wrA       = 1'b1;
                        w_nextCount = r_count + ONE;
                    end
                end
                OP_POP: begin
                    if (!w_hasOne) begin
                        w_setUn = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_nextCount = r_count - ONE;
                    end
                end
                OP_REPLACE: begin
                    if (!w_hasOne) begin
                        w_setUn = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_wrA    = 1'b1;
                        w_wrAIdx = w_tosIdx;
                    end
                end
                OP_BINOP: begin
                    if (!w_hasTwo) begin
                        w_setUn = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_wrA       = 1'b1;
                        w_wrAIdx    = w_nosIdx;
                        w_nextCount = r_count - ONE;
                    end
                end
                OP_DUP: begin
                    if (!w_hasOne) begin
                        w_setUn = 1'b1;
                    end else if (w_full) begin
                        w_setOv = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_wrA       = 1'b1;
                        w_wrAData   = w_tos;
                        w_nextCount = r_count + ONE;
                    end
                end
                OP_SWAP: begin
                    if (!w_hasTwo) begin
                        w_setUn = 1'b1;
                    end else begin
                        w_accept  = 1'b1;
                        w_wrA     = 1'b1;
                        w_wrAIdx  = w_tosIdx;
                        w_wrAData = w_nos;
                        w_wrB     = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    w_accept    = 1'b1;
                    w_clear     = 1'b1;
                    w_nextCount = '0;
                end
                default: ;
            endcase
        end
    end

    // Storage carries no reset; COUNT gates what is visible.
    always_ff @(posedge clk) begin
        if (w_wrA) r_mem[w_wrAIdx] <= w_wrAData;
        if (w_wrB) r_mem[w_wrBIdx] <= w_wrBData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_highWater <= '0;
            r_opDone    <= 1'b0;
            r_errOv     <= 1'b0;
            r_errUn     <= 1'b0;
        end else begin
            r_count  <= w_nextCount;
            r_opDone <= w_accept;
            if (w_clear) begin
                r_errOv     <= 1'b0;
                r_errUn     <= 1'b0;
                r_highWater <= '0;
            end else begin
                r_errOv <= r_errOv | w_setOv;
                r_errUn <= r_errUn | w_setUn;
                if (w_nextCount > r_highWater) r_highWater <= w_nextCount;
            end
        end
    end

    assign TOS_OUT       = w_hasOne ? w_tos : '0;
    assign NOS_OUT       = w_hasTwo ? w_nos : '0;
    assign COUNT         = r_count;
    assign EMPTY         = !w_hasOne;
    assign FULL          = w_full;
    assign OP_DONE       = r_opDone;
    assign ERR_OVERFLOW  = r_errOv;
    assign ERR_UNDERFLOW = r_errUn;
    assign HIGH_WATER    = r_highWater;

endmodule

// File: tb/tb_pam_op_stack.sv
// Directed self-checking bench for pam_op_stack: a default 8x16 instance and a 16x4 instance.
module tb_pam_op_stack;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPLACE = 3'd3,
                           BINOP = 3'd4, DUP = 3'd5, SWAP = 3'd6, CLEAR = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        valid0 = 1'b0;
    logic [2:0]  op0 = NOP;
    logic [7:0]  din0 = '0;
    logic [7:0]  tos0, nos0;
    logic [4:0]  count0, hw0;
    logic        empty0, full0, done0, ov0, un0;

    logic        valid1 = 1'b0;
    logic [2:0]  op1 = NOP;
    logic [15:0] din1 = '0;
    logic [15:0] tos1, nos1;
    logic [2:0]  count1, hw1;
    logic        empty1, full1, done1, ov1, un1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pam_op_stack dutA (
        .clk(clk), .reset(reset), .OP_VALID(valid0), .OP(op0), .DIN(din0),
        .TOS_OUT(tos0), .NOS_OUT(nos0), .COUNT(count0), .EMPTY(empty0), .FULL(full0),
        .OP_DONE(done0), .ERR_OVERFLOW(ov0), .ERR_UNDERFLOW(un0), .HIGH_WATER(hw0)
    );

    pam_op_stack #(.DATA_WIDTH(16), .DEPTH(4)) dutB (
        .clk(clk), .reset(reset), .OP_VALID(valid1), .OP(op1), .DIN(din1),
        .TOS_OUT(tos1), .NOS_OUT(nos1), .COUNT(count1), .EMPTY(empty1), .FULL(full1),
        .OP_DONE(done1), .ERR_OVERFLOW(ov1), .ERR_UNDERFLOW(un1), .HIGH_WATER(hw1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one op on the chosen instance for a single edge, then sample 1ns after it.
    task automatic applyStimulus(input int inst, input logic vld, input logic [2:0] op, input logic [15:0] din);
        @(negedge clk);
        if (inst == 0) begin
            valid0 = vld;
            op0    = op;
            din0   = din[7:0];
        end else begin
            valid1 = vld;
            op1    = op;
            din1   = din;
        end
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    initial begin
        #12;
        checkOutput("rst_count", count0, 0);
        checkOutput("rst_empty", empty0, 1);
        checkOutput("rst_full", full0, 0);
        checkOutput("rst_tos", tos0, 0);
        checkOutput("rst_nos", nos0, 0);
        checkOutput("rst_done", done0, 0);
        checkOutput("rst_ov", ov0, 0);
        checkOutput("rst_un", un0, 0);
        checkOutput("rst_hw", hw0, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_count", count0, 0);
        checkOutput("idle_done", done0, 0);

        // Asynchronous reset mid-stream
        for (int i = 1; i <= 3; i++) applyStimulus(0, 1'b1, PUSH, 16'(i));
        checkOutput("mid_count_pre", count0, 3);
        checkOutput("mid_tos_pre", tos0, 8'h03);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_count_async", count0, 0);
        checkOutput("mid_tos_async", tos0, 0);
        checkOutput("mid_hw_async", hw0, 0);
        checkOutput("mid_done_async", done0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Fill to full, then overflow by PUSH and DUP
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 1'b1, PUSH, 16'(i));
            checkOutput("fill_done", done0, 1);
        end
        checkOutput("fill_full", full0, 1);
        checkOutput("fill_count", count0, 16);
        checkOutput("fill_tos", tos0, 8'h10);
        checkOutput("fill_nos", nos0, 8'h0F);
        checkOutput("fill_hw", hw0, 16);
        applyStimulus(0, 1'b1, PUSH, 16'h00AA);
        checkOutput("ovf_flag", ov0, 1);
        checkOutput("ovf_done", done0, 0);
        checkOutput("ovf_tos", tos0, 8'h10);
        checkOutput("ovf_count", count0, 16);
        applyStimulus(0, 1'b1, DUP, 16'h0);
        checkOutput("dupovf_flag", ov0, 1);
        checkOutput("dupovf_count", count0, 16);
        checkOutput("dupovf_un", un0, 0);
        checkOutput("dupovf_done", done0, 0);
        applyStimulus(0, 1'b1, CLEAR, 16'h0);
        checkOutput("clr1_count", count0, 0);
        checkOutput("clr1_ov", ov0, 0);
        checkOutput("clr1_hw", hw0, 0);
        checkOutput("clr1_done", done0, 1);
        checkOutput("clr1_tos", tos0, 0);

        // Underflow cases
        applyStimulus(0, 1'b1, POP, 16'h0);
        checkOutput("popunf_flag", un0, 1);
        checkOutput("popunf_count", count0, 0);
        checkOutput("popunf_done", done0, 0);
        applyStimulus(0, 1'b1, PUSH, 16'h0005);
        applyStimulus(0, 1'b1, BINOP, 16'h0007);
        checkOutput("binunf_flag", un0, 1);
        checkOutput("binunf_tos", tos0, 8'h05);
        checkOutput("binunf_count", count0, 1);
        checkOutput("binunf_done", done0, 0);
        checkOutput("binunf_ov", ov0, 0);
        applyStimulus(0, 1'b1, CLEAR, 16'h0);

        // Back-to-back BINOP write-back
        applyStimulus(0, 1'b1, PUSH, 16'h0003);
        checkOutput("b2b_done1", done0, 1);
        applyStimulus(0, 1'b1, PUSH, 16'h0004);
        checkOutput("b2b_done2", done0, 1);
        checkOutput("b2b_nos_pre", nos0, 8'h03);
        applyStimulus(0, 1'b1, BINOP, 16'h0007);
        checkOutput("b2b_done3", done0, 1);
        checkOutput("b2b_count", count0, 1);
        checkOutput("b2b_tos", tos0, 8'h07);
        checkOutput("b2b_nos", nos0, 0);
        checkOutput("b2b_hw", hw0, 2);
        applyStimulus(0, 1'b1, CLEAR, 16'h0);

        // SWAP / DUP / REPLACE
        applyStimulus(0, 1'b1, PUSH, 16'h0011);
        applyStimulus(0, 1'b1, PUSH, 16'h0022);
        applyStimulus(0, 1'b1, SWAP, 16'h0);
        checkOutput("swap_tos", tos0, 8'h11);
        checkOutput("swap_nos", nos0, 8'h22);
        checkOutput("swap_done", done0, 1);
        applyStimulus(0, 1'b1, DUP, 16'h0);
        checkOutput("dup_count", count0, 3);
        checkOutput("dup_tos", tos0, 8'h11);
        checkOutput("dup_nos", nos0, 8'h11);
        applyStimulus(0, 1'b1, REPLACE, 16'h0099);
        checkOutput("repl_tos", tos0, 8'h99);
        checkOutput("repl_nos", nos0, 8'h11);
        checkOutput("repl_count", count0, 3);
        applyStimulus(0, 1'b1, POP, 16'h0);
        checkOutput("pop_count", count0, 2);
        checkOutput("pop_tos", tos0, 8'h11);
        checkOutput("pop_nos", nos0, 8'h22);
        checkOutput("pop_hw", hw0, 3);

        // NOP and OP_VALID low have no effect
        applyStimulus(0, 1'b1, NOP, 16'h0);
        checkOutput("nop_done", done0, 0);
        checkOutput("nop_count", count0, 2);
        applyStimulus(0, 1'b0, PUSH, 16'h0055);
        checkOutput("novalid_count", count0, 2);
        checkOutput("novalid_tos", tos0, 8'h11);
        checkOutput("novalid_done", done0, 0);

        // Underflow flag plus high water of 5, then CLEAR
        applyStimulus(0, 1'b1, CLEAR, 16'h0);
        applyStimulus(0, 1'b1, REPLACE, 16'h0001);
        checkOutput("replunf_flag", un0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, PUSH, 16'(8'h40 + i));
        for (int i = 0; i < 2; i++) applyStimulus(0, 1'b1, POP, 16'h0);
        checkOutput("hw5_hw", hw0, 5);
        checkOutput("hw5_count", count0, 3);
        checkOutput("hw5_un_sticky", un0, 1);
        applyStimulus(0, 1'b1, CLEAR, 16'h0);
        checkOutput("clr2_count", count0, 0);
        checkOutput("clr2_un", un0, 0);
        checkOutput("clr2_ov", ov0, 0);
        checkOutput("clr2_hw", hw0, 0);
        checkOutput("clr2_done", done0, 1);
        checkOutput("clr2_empty", empty0, 1);

        // Wide, shallow instance
        checkOutput("b_rst_count", count1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b1, PUSH, 16'hBEEF);
        checkOutput("b_full", full1, 1);
        checkOutput("b_count", count1, 4);
        checkOutput("b_tos", tos1, 16'hBEEF);
        checkOutput("b_nos", nos1, 16'hBEEF);
        checkOutput("b_hw", hw1, 4);
        applyStimulus(1, 1'b1, PUSH, 16'h1234);
        checkOutput("b_ovf_flag", ov1, 1);
        checkOutput("b_ovf_done", done1, 0);
        checkOutput("b_ovf_count", count1, 4);
        applyStimulus(1, 1'b1, REPLACE, 16'hCAFE);
        checkOutput("b_repl_tos", tos1, 16'hCAFE);
        checkOutput("b_repl_ov_sticky", ov1, 1);
        applyStimulus(1, 1'b1, CLEAR, 16'h0);
        checkOutput("b_clr_ov", ov1, 0);
        checkOutput("b_clr_hw", hw1, 0);
        checkOutput("b_clr_full", full1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
